// File: rtl/find_max_tree_if.sv
// Handshake bundle for find_max_tree: upstream window channel plus downstream result channel.
// Index_Out is present only when FIND_MAX_INDEX_EN is defined.
interface find_max_tree_if #(
  parameter int N_IN = 9
);
`ifdef FIND_MAX_INDEX_EN
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
`endif

  logic [32*N_IN-1:0] Data_In;
  logic               Mode;
  logic               Valid_In;
  logic               Ready_In;
  logic [31:0]        Data_Out;
  logic               Valid_Out;
  logic               Ready_Out;
`ifdef FIND_MAX_INDEX_EN
  logic [IW-1:0]      Index_Out;
`endif

  modport master (
    output Data_In,
    output Mode,
    output Valid_In,
    input  Ready_In,
    input  Data_Out,
    input  Valid_Out,
    output Ready_Out
`ifdef FIND_MAX_INDEX_EN
    , input Index_Out
`endif
  );

  modport slave (
    input  Data_In,
    input  Mode,
    input  Valid_In,
    output Ready_In,
    output Data_Out,
    output Valid_Out,
    input  Ready_Out
`ifdef FIND_MAX_INDEX_EN
    , output Index_Out
`endif
  );
endinterface

// File: rtl/find_max_tree.sv
// Pipelined FP32 max/min reduction tree, one comparator level per stage, global stall enable.
// Optional macro FIND_MAX_INDEX_EN adds per-stage index registers and the Index_Out port.
module find_max_tree #(
  parameter int N_IN = 9
) (
  input logic            clk,
  input logic            rst,
  find_max_tree_if.slave bus
);
  localparam int LAT = (N_IN > 1) ? $clog2(N_IN) : 1;
`ifdef FIND_MAX_INDEX_EN
  localparam int IW  = LAT;
`endif

  function automatic int lvl_cnt(input int lvl);
    int c;
    c = N_IN;
    for (int k = 0; k < lvl; k++) c = (c + 1) / 2;
    return c;
  endfunction

  // Elements of all levels are packed back to back; level s starts at lvl_base(s).
  function automatic int lvl_base(input int lvl);
    int b;
    b = 0;
    for (int k = 1; k < lvl; k++) b = b + lvl_cnt(k);
    return b;
  endfunction

  localparam int TOT = lvl_base(LAT + 1);

  // Monotonic unsigned key: negative values bit-flipped, positive values sign-flipped.
  function automatic logic [31:0] fp_key(input logic [31:0] x);
    return x[31] ? ~x : {1'b1, x[30:0]};
  endfunction

  logic        en_s;
  logic [31:0] data_q [TOT];
  logic [31:0] data_d [TOT];
  logic        mode_q [LAT];
  logic        mode_d [LAT];
  logic        vld_q  [LAT];
  logic        vld_d  [LAT];
`ifdef FIND_MAX_INDEX_EN
  logic [IW-1:0] idx_q [TOT];
  logic [IW-1:0] idx_d [TOT];
`endif

  assign en_s          = ~vld_q[LAT-1] | bus.Ready_Out;
  assign bus.Ready_In  = en_s;
  assign bus.Data_Out  = data_q[TOT-1];
  assign bus.Valid_Out = vld_q[LAT-1];
`ifdef FIND_MAX_INDEX_EN
  assign bus.Index_Out = idx_q[TOT-1];
`endif

  for (genvar s = 1; s <= LAT; s++) begin : g_lvl
    localparam int NI = lvl_cnt(s - 1);
    localparam int NO = lvl_cnt(s);
    localparam int OB = lvl_base(s);
    localparam int IB = (s > 1) ? lvl_base(s - 1) : 0;
    logic mode_s;

    if (s == 1) begin : g_ctl
      assign mode_s   = bus.Mode;
      assign mode_d[0] = bus.Mode;
      assign vld_d[0]  = bus.Valid_In;
    end else begin : g_ctl
      assign mode_s     = mode_q[s-2];
      assign mode_d[s-1] = mode_q[s-2];
      assign vld_d[s-1]  = vld_q[s-2];
    end

    for (genvar j = 0; j < NO; j++) begin : g_node
      // An unpaired element compares against itself, so it passes through unchanged.
      localparam int JA = 2 * j;
      localparam int JB = (2 * j + 1 < NI) ? 2 * j + 1 : 2 * j;
      logic [31:0] a_s;
      logic [31:0] b_s;
      logic        take_b_s;

      if (s == 1) begin : g_src
        assign a_s = bus.Data_In[32*JA +: 32];
        assign b_s = bus.Data_In[32*JB +: 32];
      end else begin : g_src
        assign a_s = data_q[IB+JA];
        assign b_s = data_q[IB+JB];
      end

      // Strict compare keeps the lower-index element on ties in both modes.
      assign take_b_s = mode_s ? (fp_key(b_s) < fp_key(a_s))
                               : (fp_key(b_s) > fp_key(a_s));
      assign data_d[OB+j] = take_b_s ? b_s : a_s;

`ifdef FIND_MAX_INDEX_EN
      logic [IW-1:0] ia_s;
      logic [IW-1:0] ib_s;
      if (s == 1) begin : g_isrc
        assign ia_s = IW'(JA);
        assign ib_s = IW'(JB);
      end else begin : g_isrc
        assign ia_s = idx_q[IB+JA];
        assign ib_s = idx_q[IB+JB];
      end
      assign idx_d[OB+j] = take_b_s ? ib_s : ia_s;
`endif
    end
  end

  // Stage registers: cleared asynchronously, advanced together under the global enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TOT; k++) begin
        data_q[k] <= 32'd0;
`ifdef FIND_MAX_INDEX_EN
        idx_q[k]  <= {IW{1'b0}};
`endif
      end
      for (int k = 0; k < LAT; k++) begin
        mode_q[k] <= 1'b0;
        vld_q[k]  <= 1'b0;
      end
    end else if (en_s) begin
      data_q <= data_d;
      mode_q <= mode_d;
      vld_q  <= vld_d;
`ifdef FIND_MAX_INDEX_EN
      idx_q  <= idx_d;
`endif
    end
  end
endmodule
